// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared glyph codes, glyph table and scan FSM encoding
package seven_seg_pkg;

  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_DASH  = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  // Segment order {a,b,c,d,e,f,g}, active-high; 16 and 18..31 are blank
  function automatic logic [6:0] glyph_lookup(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'd0:      g = 7'b1111110;
      5'd1:      g = 7'b0110000;
      5'd2:      g = 7'b1101101;
      5'd3:      g = 7'b1111001;
      5'd4:      g = 7'b0110011;
      5'd5:      g = 7'b1011011;
      5'd6:      g = 7'b1011111;
      5'd7:      g = 7'b1110000;
      5'd8:      g = 7'b1111111;
      5'd9:      g = 7'b1111011;
      5'd10:     g = 7'b1110111;
      5'd11:     g = 7'b0011111;
      5'd12:     g = 7'b1001110;
      5'd13:     g = 7'b0111101;
      5'd14:     g = 7'b1001111;
      5'd15:     g = 7'b1000111;
      CODE_DASH: g = 7'b0000001;
      default:   g = 7'b0000000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seven_seg_glyph_rom.sv
// rtl/seven_seg_glyph_rom.sv - combinational 5-bit glyph code to 7-segment decode
module seven_seg_glyph_rom
  import seven_seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  assign seg = glyph_lookup(code);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - multiplexed N-digit seven-segment driver with
// blank guard per slot and frame-boundary content update
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 12000,
  parameter int BLANK_CYCLES   = 200,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [5*NUM_DIGITS-1:0] load_codes,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};
  localparam logic [5*NUM_DIGITS-1:0] CODES_RST = {NUM_DIGITS{CODE_BLANK}};

  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic [5*NUM_DIGITS-1:0] act_codes_q, act_codes_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [5*NUM_DIGITS-1:0] pend_codes_q, pend_codes_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_q, pend_d;

  logic                    load_ready_q, load_ready_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    frame_start_q, frame_start_d;

  logic [4:0]              cur_code;
  logic [6:0]              cur_glyph;
  logic                    frame_edge;
  logic                    show;

  assign cur_code = act_codes_q[5*int'(idx_q) +: 5];

  seven_seg_glyph_rom u_glyph_rom (
    .code (cur_code),
    .seg  (cur_glyph)
  );

  // First GUARD cycle of digit 0 is the only point where content may change
  assign frame_edge = (state_q == ST_GUARD) && (idx_q == '0) && (cnt_q == '0);
  assign show       = enable && (state_q == ST_SHOW);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_GUARD;
          cnt_d   = '0;
          idx_d   = '0;
        end
        ST_GUARD: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == GUARD_LAST) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Capture needs load_ready_q, which is low whenever pending is set, so a
  // capture and an apply can never happen in the same cycle.
  always_comb begin
    act_codes_d  = act_codes_q;
    act_dp_d     = act_dp_q;
    pend_codes_d = pend_codes_q;
    pend_dp_d    = pend_dp_q;
    pend_d       = pend_q;
    if (pend_q && ((state_q == ST_IDLE) || frame_edge)) begin
      act_codes_d = pend_codes_q;
      act_dp_d    = pend_dp_q;
      pend_d      = 1'b0;
    end else if (load_valid && load_ready_q) begin
      pend_codes_d = load_codes;
      pend_dp_d    = load_dp;
      pend_d       = 1'b1;
    end
    load_ready_d = !pend_d;
  end

  always_comb begin
    seg_d         = (show ? cur_glyph : 7'b0) ^ SEG_OFF;
    dp_d          = (show && act_dp_q[idx_q]) ^ SEG_ACTIVE_LOW;
    dig_d         = (show ? (NUM_DIGITS'(1) << idx_q) : '0) ^ DIG_OFF;
    frame_start_d = enable && frame_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      act_codes_q   <= CODES_RST;
      act_dp_q      <= '0;
      pend_codes_q  <= CODES_RST;
      pend_dp_q     <= '0;
      pend_q        <= 1'b0;
      load_ready_q  <= 1'b1;
      seg_q         <= SEG_OFF;
      dp_q          <= SEG_ACTIVE_LOW;
      dig_q         <= DIG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      act_codes_q   <= act_codes_d;
      act_dp_q      <= act_dp_d;
      pend_codes_q  <= pend_codes_d;
      pend_dp_q     <= pend_dp_d;
      pend_q        <= pend_d;
      load_ready_q  <= load_ready_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dig_q         <= dig_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign load_ready  = load_ready_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign dig         = dig_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - directed self-checking bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load_valid;
  logic [19:0] load_codes;
  logic [3:0]  load_dp;

  logic        load_ready, dp, frame_start;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic        load_ready2, dp2, frame_start2;
  logic [6:0]  seg2;
  logic [3:0]  dig2;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_codes(load_codes), .load_dp(load_dp),
    .seg(seg), .dp(dp), .dig(dig), .frame_start(frame_start)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) u_dut_lo (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .load_valid(load_valid), .load_ready(load_ready2),
    .load_codes(load_codes), .load_dp(load_dp),
    .seg(seg2), .dp(dp2), .dig(dig2), .frame_start(frame_start2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_glyph(input logic [4:0] c);
    case (c)
      5'd0:  return 7'b1111110;
      5'd1:  return 7'b0110000;
      5'd2:  return 7'b1101101;
      5'd3:  return 7'b1111001;
      5'd4:  return 7'b0110011;
      5'd5:  return 7'b1011011;
      5'd6:  return 7'b1011111;
      5'd7:  return 7'b1110000;
      5'd8:  return 7'b1111111;
      5'd9:  return 7'b1111011;
      5'd10: return 7'b1110111;
      5'd11: return 7'b0011111;
      5'd12: return 7'b1001110;
      5'd13: return 7'b0111101;
      5'd14: return 7'b1001111;
      5'd15: return 7'b1000111;
      5'd17: return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input string tag);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (frame_start === 1'b1) seen = 1;
      else tick();
    end
    check({tag, "_fs_timeout"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic load_idle(input logic [19:0] codes, input logic [3:0] dpv, input string tag);
    load_codes = codes;
    load_dp    = dpv;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check({tag, "_ready_low"}, {31'd0, load_ready}, 32'd0);
    tick();
    check({tag, "_ready_back"}, {31'd0, load_ready}, 32'd1);
  endtask

  // Expects to start on the cycle frame_start is visible (k=0) and leaves on the next k=0
  task automatic run_frame(input string tag, input logic [19:0] codes, input logic [3:0] dpv,
                           input int inj_k, input logic [19:0] inj_codes, input logic [3:0] inj_dp,
                           input int inj2_k, input logic [19:0] inj2_codes);
    for (int k = 0; k < 32; k++) begin
      int  d    = k / 8;
      bit  on   = (k % 8) >= 2;
      logic [3:0] edig = on ? ~(4'b0001 << d) : 4'b1111;
      logic [6:0] eseg = on ? exp_glyph(codes[5*d +: 5]) : 7'b0;
      logic       edp  = on ? dpv[d] : 1'b0;
      logic       elr  = (inj_k >= 0 && k > inj_k) ? 1'b0 : 1'b1;
      check($sformatf("%s_dig_k%0d", tag, k), {28'd0, dig}, {28'd0, edig});
      check($sformatf("%s_seg_k%0d", tag, k), {25'd0, seg}, {25'd0, eseg});
      check($sformatf("%s_dp_k%0d", tag, k), {31'd0, dp}, {31'd0, edp});
      check($sformatf("%s_fs_k%0d", tag, k), {31'd0, frame_start}, {31'd0, k == 0});
      check($sformatf("%s_rdy_k%0d", tag, k), {31'd0, load_ready}, {31'd0, elr});
      load_valid = (k == inj_k) || (k == inj2_k);
      load_codes = (k == inj2_k) ? inj2_codes : inj_codes;
      load_dp    = (k == inj2_k) ? 4'b1111 : inj_dp;
      tick();
    end
    load_valid = 1'b0;
  endtask

  localparam logic [19:0] BLANKS = {4{5'd16}};
  localparam logic [19:0] C3210  = {5'd3, 5'd2, 5'd1, 5'd0};
  localparam logic [19:0] CFEDC  = {5'd15, 5'd14, 5'd13, 5'd12};
  localparam logic [19:0] C8888  = {4{5'd8}};
  localparam logic [19:0] CDASH  = {4{5'd17}};

  initial begin
    rst_n = 1'b0; enable = 1'b0; load_valid = 1'b0; load_codes = '0; load_dp = '0;
    tick(); tick();
    check("rst_dig", {28'd0, dig}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h0);
    check("rst_dp", {31'd0, dp}, 32'h0);
    check("rst_ready", {31'd0, load_ready}, 32'h1);
    check("rst_fs", {31'd0, frame_start}, 32'h0);
    check("rst_seg_lo", {25'd0, seg2}, 32'h7F);
    check("rst_dp_lo", {31'd0, dp2}, 32'h1);

    // Blank scan straight out of reset
    rst_n = 1'b1; enable = 1'b1;
    wait_frame("t1");
    run_frame("t1a", BLANKS, 4'b0000, -1, '0, '0, -1, '0);
    run_frame("t1b", BLANKS, 4'b0000, -1, '0, '0, -1, '0);

    // Load while idle, then scan it
    enable = 1'b0;
    tick();
    check("t2_off_dig", {28'd0, dig}, 32'hF);
    load_idle(C3210, 4'b0001, "t2");
    enable = 1'b1;
    wait_frame("t2");
    run_frame("t2", C3210, 4'b0001, -1, '0, '0, -1, '0);

    // Mid-frame load held to the boundary; second load while pending is ignored
    run_frame("t3old", C3210, 4'b0001, 10, CFEDC, 4'b0000, 20, C8888);
    run_frame("t3new", CFEDC, 4'b0000, -1, '0, '0, -1, '0);

    // Drop enable in digit 2 SHOW, then restart at digit 0
    for (int i = 0; i < 19; i++) tick();
    check("t5_dig2_on", {28'd0, dig}, 32'hB);
    enable = 1'b0;
    tick();
    check("t5_off_dig", {28'd0, dig}, 32'hF);
    check("t5_off_seg", {25'd0, seg}, 32'h0);
    tick(); tick();
    check("t5_idle_dig", {28'd0, dig}, 32'hF);
    enable = 1'b1;
    tick();
    check("t5_fs_early", {31'd0, frame_start}, 32'h0);
    tick();
    check("t5_fs_restart", {31'd0, frame_start}, 32'h1);
    run_frame("t5", CFEDC, 4'b0000, -1, '0, '0, -1, '0);

    // Dash through both polarities, then async reset mid-SHOW
    enable = 1'b0;
    tick();
    load_idle(CDASH, 4'b0000, "t6");
    enable = 1'b1;
    wait_frame("t6");
    tick(); tick(); tick();
    check("t6_seg", {25'd0, seg}, 32'h01);
    check("t6_seg_lo", {25'd0, seg2}, {25'd0, 7'b1111110});
    check("t6_dp_lo", {31'd0, dp2}, 32'h1);
    check("t6_dig_lo", {28'd0, dig2}, 32'hE);
    rst_n = 1'b0;
    #1;
    check("t6_rst_dig", {28'd0, dig}, 32'hF);
    check("t6_rst_seg", {25'd0, seg}, 32'h0);
    check("t6_rst_dig_lo", {28'd0, dig2}, 32'hF);
    check("t6_rst_seg_lo", {25'd0, seg2}, 32'h7F);
    check("t6_rst_dp_lo", {31'd0, dp2}, 32'h1);
    check("t6_rst_ready", {31'd0, load_ready}, 32'h1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
